// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer slot scheduler between the camera writer and HDMI reader, with write timeout and stats.
// Latency: registered outputs follow a detected event by one clock; no backpressure, events are never stalled.
module frame_buffer_scheduler #(
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter logic [31:0] FRAME_STRIDE   = 32'h0004_0000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd4_000_000
) (
  input  logic        clk_100Mhz,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr_frame_start,
  input  logic        writer_done,
  input  logic        rd_frame_start,
  output logic [31:0] wr_base_addr,
  output logic [31:0] rd_base_addr,
  output logic [1:0]  wr_idx,
  output logic [1:0]  rd_idx,
  output logic        wr_active,
  output logic [15:0] frames_written,
  output logic [15:0] frames_dropped,
  output logic [15:0] frames_repeated,
  output logic [7:0]  timeout_cnt
);

  typedef enum logic {W_IDLE, W_ACTIVE} wst_t;

  wst_t        st_q, st_d;
  logic [1:0]  w_q, w_d, l_q, l_d, r_q, r_d;
  logic        fresh_q, fresh_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic [15:0] written_q, written_d, dropped_q, dropped_d, repeated_q, repeated_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        wfs_d1_q, done_d1_q;
  logic [31:0] wr_addr_q, rd_addr_q;
  logic        wr_act_q;
  logic [1:0]  wr_idx_q, rd_idx_q;
  logic        wfs_edge, done_edge, commit;

  function automatic logic [31:0] slot_addr(input logic [1:0] idx);
    return BASE_ADDR + FRAME_STRIDE * {30'd0, idx};
  endfunction

  assign wfs_edge  = wr_frame_start & ~wfs_d1_q;
  assign done_edge = writer_done & ~done_d1_q;
  assign commit    = enable && (st_q == W_ACTIVE) && done_edge;

  always_comb begin
    st_d       = st_q;
    w_d        = w_q;
    l_d        = l_q;
    r_d        = r_q;
    fresh_d    = fresh_q;
    tcnt_d     = tcnt_q;
    written_d  = written_q;
    dropped_d  = dropped_q;
    repeated_d = repeated_q;
    tmo_d      = tmo_q;
    if (enable) begin
      // A restart edge wins over done/timeout: the in-flight frame is abandoned.
      if (wfs_edge) begin
        st_d   = W_ACTIVE;
        tcnt_d = '0;
      end else if (st_q == W_ACTIVE) begin
        if (done_edge) begin
          st_d = W_IDLE;
        end else if (tcnt_q == TIMEOUT_CYCLES - 32'd1) begin
          st_d = W_IDLE;
          if (tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
        end
      end
      if (commit && !wfs_edge) begin
        w_d       = l_q;
        l_d       = w_q;
        written_d = written_q + 16'd1;
        if (fresh_q) dropped_d = dropped_q + 16'd1;
        fresh_d = 1'b1;
      end
      // Reader swap sees the post-commit L/fresh so a same-cycle commit is displayed at once.
      if (rd_frame_start) begin
        if (fresh_d) begin
          r_d     = l_d;
          l_d     = r_q;
          fresh_d = 1'b0;
        end else begin
          repeated_d = repeated_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      st_q       <= W_IDLE;
      w_q        <= 2'd0;
      l_q        <= 2'd1;
      r_q        <= 2'd2;
      fresh_q    <= 1'b0;
      tcnt_q     <= '0;
      written_q  <= '0;
      dropped_q  <= '0;
      repeated_q <= '0;
      tmo_q      <= '0;
      wfs_d1_q   <= 1'b0;
      done_d1_q  <= 1'b0;
      wr_addr_q  <= BASE_ADDR;
      rd_addr_q  <= BASE_ADDR + FRAME_STRIDE * 32'd2;
      wr_act_q   <= 1'b0;
      wr_idx_q   <= 2'd0;
      rd_idx_q   <= 2'd2;
    end else begin
      st_q       <= st_d;
      w_q        <= w_d;
      l_q        <= l_d;
      r_q        <= r_d;
      fresh_q    <= fresh_d;
      tcnt_q     <= tcnt_d;
      written_q  <= written_d;
      dropped_q  <= dropped_d;
      repeated_q <= repeated_d;
      tmo_q      <= tmo_d;
      wfs_d1_q   <= wr_frame_start;
      done_d1_q  <= writer_done;
      wr_addr_q  <= slot_addr(w_d);
      rd_addr_q  <= slot_addr(r_d);
      wr_act_q   <= (st_d == W_ACTIVE);
      wr_idx_q   <= w_d;
      rd_idx_q   <= r_d;
    end
  end

  assign wr_base_addr    = wr_addr_q;
  assign rd_base_addr    = rd_addr_q;
  assign wr_idx          = wr_idx_q;
  assign rd_idx          = rd_idx_q;
  assign wr_active       = wr_act_q;
  assign frames_written  = written_q;
  assign frames_dropped  = dropped_q;
  assign frames_repeated = repeated_q;
  assign timeout_cnt     = tmo_q;

endmodule

// File: doc/frame_buffer_scheduler.md
Name: frame_buffer_scheduler

Overview:
- Triple-buffer scheduler for the camera-to-DDR path.
- Owns three DDR frame slots and assigns one to the AXI4 stream-to-MM writer (FRAME_BASE_ADDR) and one to the HDMI DDR reader.
- Swaps slots on writer completion and at reader frame start, so the display never reads a frame while it is being written.
- Runs in the clk_100Mhz domain. Also supervises each write frame with a timeout and keeps drop, repeat and timeout statistics.

Parameters:
- BASE_ADDR, 32'h1000_0000, DDR address of slot 0.
- FRAME_STRIDE, 32'h0004_0000, byte distance between slots; must be ≥ 153600 (320x240x2).
- TIMEOUT_CYCLES, 32'd4_000_000, maximum clk_100Mhz cycles from write-frame start to writer_done.

Ports:
- clk_100Mhz  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = scheduling active; 0 = freeze slot indices and ignore all events.
- wr_frame_start  in  1  level from capture (frame_done), already in clk_100Mhz domain; rising edge = a new write frame begins.
- writer_done  in  1  from the writer; rising edge = frame fully committed to DDR.
- rd_frame_start  in  1  single-cycle pulse from the reader at start of a display frame (synchronised).
- wr_base_addr  out  32  frame base address for the writer.
- rd_base_addr  out  32  frame base address for the reader.
- wr_idx  out  2  slot index being written.
- rd_idx  out  2  slot index being displayed.
- wr_active  out  1  1 while in W_ACTIVE.
- frames_written  out  16  completed write frames.
- frames_dropped  out  16  completed frames overwritten before being displayed.
- frames_repeated  out  16  reader frame starts with no fresh frame.
- timeout_cnt  out  8  aborted write frames.

Behaviour:
- Internal state:
  - Indices W, L (latest complete), R; always pairwise distinct, each in {0,1,2}.
  - Flag fresh.
  - Writer FSM: W_IDLE / W_ACTIVE.
  - 32-bit timeout counter tcnt.
- Reset values:
  - W=0, L=1, R=2, fresh=0, FSM=W_IDLE, tcnt=0.
  - wr_base_addr=BASE_ADDR; rd_base_addr=BASE_ADDR+2*FRAME_STRIDE; wr_idx=0; rd_idx=2; wr_active=0.
  - All counters 0.
  - Edge-detect registers for wr_frame_start and writer_done cleared to 0, so an input already high at reset exit does not create an edge.
- Edge detection: one registered delay per level input; edge = in & ~in_d1.
- Writer FSM:
  - W_IDLE: on wr_frame_start edge → W_ACTIVE, tcnt=0.
  - W_ACTIVE, writer_done edge → W_IDLE and commit.
  - W_ACTIVE, no done and tcnt == TIMEOUT_CYCLES-1 → W_IDLE, timeout_cnt+1 (saturating), no commit; the slot is rewritten on the next frame.
  - Otherwise in W_ACTIVE: tcnt+1.
  - wr_frame_start edge while in W_ACTIVE: restart tcnt=0, stay in W_ACTIVE, no commit.
  - writer_done edge while in W_IDLE: ignored.
- Commit (writer complete):
  - W←L, L←W, frames_written+1.
  - If fresh was already 1, frames_dropped+1.
  - fresh←1.
- Reader swap (rd_frame_start while enable):
  - If fresh: R←L, L←R, fresh←0.
  - Otherwise: frames_repeated+1, indices unchanged.
- Simultaneous commit and rd_frame_start in one cycle:
  - Commit is applied first, then the reader swap uses the post-commit L and fresh.
  - The reader therefore gets the just-completed frame and fresh ends at 0.
  - If fresh was 1 before the commit, frames_dropped still increments.
- Outputs:
  - Registered: wr_base_addr = BASE_ADDR + W*FRAME_STRIDE, rd_base_addr likewise from R, both modulo 2^32.
  - Outputs reflect an event one cycle after the edge is detected (two cycles after an input rises for level inputs; one cycle after an rd_frame_start pulse).
  - wr_base_addr changes only at commit and is stable throughout W_ACTIVE.
- Counters: 16-bit wrap modulo 2^16; timeout_cnt saturates at 255.
- enable=0:
  - W, L, R, fresh, FSM and tcnt hold.
  - Edge registers keep sampling, so no stale edges fire on re-enable.
  - Counters hold.
- rst asserted mid-frame: all state returns to reset values on that clock edge; any in-flight frame is discarded silently.

Test Plan:
- After rst, enable=1, one write frame completes and one rd_frame_start follows:
  - After commit: W=1, L=0, wr_base_addr=0x1004_0000.
  - After the reader pulse: R=0, rd_base_addr=0x1000_0000, L=2, frames_written=1.
- Two write frames complete with no rd_frame_start between them → frames_dropped=1, fresh=1; the next rd_frame_start displays the second frame (its slot index is what L was after commit 2).
- Three rd_frame_start pulses with no writes → frames_repeated=3, rd_idx stays 2, rd_base_addr=0x1008_0000.
- TIMEOUT_CYCLES=100 and wr_frame_start rises with no writer_done:
  - 100 cycles later wr_active=0, timeout_cnt=1, W unchanged, frames_written=0.
  - A writer_done edge afterwards is ignored.
- writer_done edge and rd_frame_start in the same cycle with fresh=0 → reader receives the new frame, fresh=0, frames_repeated=0, frames_dropped=0.
- Assert rst for 1 cycle while in W_ACTIVE with W=1 → next cycle W=0, wr_base_addr=0x1000_0000, all counters 0, wr_active=0.
